if_fetch: RTL and testbench

Instruction-fetch stage of the RV32S pipeline: the sending end of the IF→ID valid/ready handshake. Generates sequential fetch addresses, issues single-outstanding requests to the instruction memory, buffers returned words with their PCs in a 2-entry queue, and presents them to ID as `IF_valid`/`inst`/`PC1_pc`. Accepts PC redirects from EX (jal/jalr/taken branch), flushing queued and in-flight wrong-path fetches.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fetch_fifo.sv | 62 ++++++
 rtl/if_fetch.sv | 116 +++++++++++
 tb/tb_if_fetch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the RV32S instruction-fetch stage.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic {
        IF_ST_FETCH   = 1'b0,
        IF_ST_DISCARD = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry {pc, inst} queue between the memory response and the IF->ID handshake.
// Flush wins over push; head is read straight from registered storage.
module if_fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // NOTE: storage is reset only because the head must read as a NOP at PC 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{pc: 32'h0, inst: INST_NOP};
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // The issue rule reserves a slot for every outstanding request, so a push into a full queue is a bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_flush && !i_pop && r_count == CW'(DEPTH)));

endmodule

// File: rtl/if_fetch.sv
// IF stage: single-outstanding sequential fetcher feeding ID through a valid/ready queue.
// EX redirects flush the queue; a wrong-path request still in flight is drained in DISCARD.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        IF_valid,
    input  logic        ID_ready,
    output logic [31:0] inst,
    output logic [31:0] PC1_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    if_state_e     r_state, w_state_next;
    logic [31:0]   r_fetch_pc, w_fetch_pc_next;
    logic [31:0]   r_req_addr, w_req_addr_next;
    logic          r_outstanding, w_outstanding_next;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_inflight;
    logic          w_issue, w_push, w_pop;
    logic [31:0]   w_target;
    fetch_entry_t  w_push_data, w_head;

    assign w_target   = redirect_pc & 32'hFFFF_FFFC;
    assign w_inflight = {1'b0, w_count} + {{CW{1'b0}}, r_outstanding};

    // A redirect suppresses a fresh issue so no wrong-path request leaves in the redirect cycle.
    assign w_issue = !rst && (r_state == IF_ST_FETCH) && !redirect
                     && (!r_outstanding || imem_ack) && (w_inflight < DEPTH_L);

    assign imem_req  = w_issue || (!rst && (r_state == IF_ST_DISCARD) && !imem_ack);
    assign imem_addr = (r_outstanding && !imem_ack) ? r_req_addr : r_fetch_pc;

    assign w_push      = !rst && imem_ack && (r_state == IF_ST_FETCH) && !redirect;
    assign w_push_data = '{pc: (r_outstanding ? r_req_addr : r_fetch_pc), inst: imem_rdata};
    assign w_pop       = IF_valid && ID_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next       = r_state;
        w_fetch_pc_next    = r_fetch_pc;
        w_req_addr_next    = r_req_addr;
        w_outstanding_next = r_outstanding;
        case (r_state)
            IF_ST_FETCH: begin
                if (redirect) begin
                    w_fetch_pc_next = w_target;
                    if (r_outstanding && !imem_ack) begin
                        w_state_next = IF_ST_DISCARD;
                    end else begin
                        w_outstanding_next = 1'b0;
                    end
                end else begin
                    if (w_issue) begin
                        w_fetch_pc_next = r_fetch_pc + 32'd4;
                        w_req_addr_next = r_fetch_pc;
                    end
                    w_outstanding_next = r_outstanding ? (w_issue || !imem_ack)
                                                       : (w_issue && !imem_ack);
                end
            end
            IF_ST_DISCARD: begin
                if (redirect) begin
                    w_fetch_pc_next = w_target;
                end
                if (imem_ack) begin
                    w_state_next       = IF_ST_FETCH;
                    w_outstanding_next = 1'b0;
                end
            end
            default: w_state_next = IF_ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IF_ST_FETCH;
            r_fetch_pc    <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_outstanding <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_req_addr    <= w_req_addr_next;
            r_outstanding <= w_outstanding_next;
        end
    end

    if_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign IF_valid = (w_count != '0);
    assign inst     = w_head.inst;
    assign PC1_pc   = w_head.pc;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a behavioural instruction memory of selectable latency.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack   = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        IF_valid;
    logic        ID_ready;
    logic [31:0] inst;
    logic [31:0] PC1_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    int          m_lat  = 0;
    bit          m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_addr = 32'h0;

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .IF_valid    (IF_valid),
        .ID_ready    (ID_ready),
        .inst        (inst),
        .PC1_pc      (PC1_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory: zero-wait answers in the request cycle; otherwise acks m_lat cycles later. Drops work on rst.
    always @(negedge clk) begin
        imem_ack = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy     = 1'b0;
                imem_ack   = 1'b1;
                imem_rdata = mem_word(m_addr);
            end
        end
        #1;
        if (!rst && imem_req && !m_busy) begin
            if (m_lat == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                m_busy = 1'b1;
                m_cnt  = m_lat;
                m_addr = imem_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !IF_valid; i++) begin
            step();
            sample();
        end
        check(tag, {31'b0, IF_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit hit;
        rst         = 1'b1;
        ID_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset values
        step();
        step();
        sample();
        check("rst_valid", {31'b0, IF_valid}, 32'd0);
        check("rst_req",   {31'b0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'h8000_0000);
        check("rst_inst",  inst,      32'h0000_0013);
        check("rst_pc",    PC1_pc,    32'h0);

        // Zero-wait streaming
        step();
        rst = 1'b0;
        sample();
        check("first_req",   {31'b0, imem_req}, 32'd1);
        check("first_addr",  imem_addr, 32'h8000_0000);
        check("first_valid", {31'b0, IF_valid}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            sample();
            check("seq_valid", {31'b0, IF_valid}, 32'd1);
            check("seq_addr",  imem_addr, 32'h8000_0000 + 32'(4 * k));
            check("seq_pc",    PC1_pc,    32'h8000_0000 + 32'(4 * (k - 1)));
            check("seq_inst",  inst,      mem_word(32'h8000_0000 + 32'(4 * (k - 1))));
        end

        // Back-pressure: queue fills to two, fetch stops, head holds
        step();
        ID_ready = 1'b0;
        sample();
        check("stall_fill_req",  {31'b0, imem_req}, 32'd1);
        check("stall_fill_addr", imem_addr, 32'h8000_0014);
        check("stall_fill_pc",   PC1_pc,    32'h8000_0010);
        for (int k = 0; k < 4; k++) begin
            step();
            sample();
            check("stall_req",   {31'b0, imem_req}, 32'd0);
            check("stall_valid", {31'b0, IF_valid}, 32'd1);
            check("stall_pc",    PC1_pc, 32'h8000_0010);
            check("stall_inst",  inst,   mem_word(32'h8000_0010));
        end
        step();
        ID_ready = 1'b1;
        sample();
        check("release_pc",  PC1_pc, 32'h8000_0010);
        check("release_req", {31'b0, imem_req}, 32'd0);
        step();
        sample();
        check("release2_pc",   PC1_pc,    32'h8000_0014);
        check("release2_inst", inst,      mem_word(32'h8000_0014));
        check("release2_addr", imem_addr, 32'h8000_0018);
        step();
        sample();
        check("resume_pc",   PC1_pc,    32'h8000_0018);
        check("resume_addr", imem_addr, 32'h8000_001C);

        // 3-cycle memory: redirect while a request is outstanding
        step();
        m_lat = 3;
        sample();
        check("slow_issue_req",  {31'b0, imem_req}, 32'd1);
        check("slow_issue_addr", imem_addr, 32'h8000_0020);
        check("slow_issue_pc",   PC1_pc,    32'h8000_001C);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0100;
        sample();
        check("redir_valid", {31'b0, IF_valid}, 32'd0);
        check("redir_req",   {31'b0, imem_req}, 32'd0);
        check("redir_addr",  imem_addr, 32'h8000_0020);
        step();
        redirect = 1'b0;
        sample();
        check("discard_req",   {31'b0, imem_req}, 32'd1);
        check("discard_addr",  imem_addr, 32'h8000_0020);
        check("discard_valid", {31'b0, IF_valid}, 32'd0);
        step();
        sample();
        check("discard_ack_req",   {31'b0, imem_req}, 32'd0);
        check("discard_ack_valid", {31'b0, IF_valid}, 32'd0);
        step();
        sample();
        check("target_req",   {31'b0, imem_req}, 32'd1);
        check("target_addr",  imem_addr, 32'h8000_0100);
        check("target_valid", {31'b0, IF_valid}, 32'd0);
        wait_valid("target_wait", 10);
        check("target_pc",   PC1_pc, 32'h8000_0100);
        check("target_inst", inst,   mem_word(32'h8000_0100));

        // Redirect in the ack cycle, misaligned target
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step();
            if (m_busy && m_cnt == 1) begin
                hit         = 1'b1;
                redirect    = 1'b1;
                redirect_pc = 32'h8000_0103;
            end
            sample();
        end
        check("ackredir_found", {31'b0, hit}, 32'd1);
        check("ackredir_req",   {31'b0, imem_req}, 32'd0);
        step();
        redirect = 1'b0;
        sample();
        check("ackredir_next_req",   {31'b0, imem_req}, 32'd1);
        check("ackredir_next_addr",  imem_addr, 32'h8000_0100);
        check("ackredir_next_valid", {31'b0, IF_valid}, 32'd0);
        wait_valid("ackredir_wait", 10);
        check("ackredir_pc", PC1_pc, 32'h8000_0100);

        // Address wrap with zero-wait memory
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        m_lat       = 0;
        sample();
        step();
        redirect = 1'b0;
        sample();
        for (int i = 0; i < 10 && !(imem_req && imem_addr == 32'hFFFF_FFF8); i++) begin
            step();
            sample();
        end
        check("wrap_start_addr", imem_addr, 32'hFFFF_FFF8);
        step();
        sample();
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc1",   PC1_pc,    32'hFFFF_FFF8);
        step();
        sample();
        check("wrap_addr2", imem_addr, 32'h0000_0000);
        check("wrap_pc2",   PC1_pc,    32'hFFFF_FFFC);
        step();
        sample();
        check("wrap_addr3", imem_addr, 32'h0000_0004);
        check("wrap_pc3",   PC1_pc,    32'h0000_0000);
        check("wrap_inst3", inst,      mem_word(32'h0000_0000));

        // Reset with an entry queued and a request in flight
        step();
        m_lat    = 3;
        ID_ready = 1'b0;
        sample();
        check("prerst_valid", {31'b0, IF_valid}, 32'd1);
        check("prerst_pc",    PC1_pc, 32'h0000_0004);
        check("prerst_req",   {31'b0, imem_req}, 32'd1);
        step();
        rst = 1'b1;
        sample();
        check("rst_cycle_req", {31'b0, imem_req}, 32'd0);
        step();
        sample();
        check("rst2_valid", {31'b0, IF_valid}, 32'd0);
        check("rst2_req",   {31'b0, imem_req}, 32'd0);
        check("rst2_addr",  imem_addr, 32'h8000_0000);
        check("rst2_inst",  inst,      32'h0000_0013);
        check("rst2_pc",    PC1_pc,    32'h0);
        step();
        rst      = 1'b0;
        ID_ready = 1'b1;
        sample();
        check("refetch_req",   {31'b0, imem_req}, 32'd1);
        check("refetch_addr",  imem_addr, 32'h8000_0000);
        check("refetch_valid", {31'b0, IF_valid}, 32'd0);
        wait_valid("refetch_wait", 10);
        check("refetch_pc",   PC1_pc, 32'h8000_0000);
        check("refetch_inst", inst,   mem_word(32'h8000_0000));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
